// File: rtl/wheel_pkg.sv
// wheel_pkg: shared speed-path constants and target/slew helpers for the wheel PWM driver.
package wheel_pkg;
  localparam int SPEED_W_DEF = 6;
  function automatic int mid_of(input int sw);
    return 1 << (sw - 1);
  endfunction
  // Mirror about MID; speed 0 would land one past full scale, so clamp it.
  function automatic int mirror_speed(input int speed, input int sw);
    int m;
    m = (1 << sw) - speed;
    return (m > (1 << sw) - 1) ? (1 << sw) - 1 : m;
  endfunction
  function automatic int slew_toward(input int cur, input int tgt, input int step);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (step == 0 || d <= step) return tgt;
    return (tgt > cur) ? cur + step : cur - step;
  endfunction
endpackage

// File: rtl/wheel_pwm_driver_if.sv
// wheel_pwm_driver_if: command inputs and pulse/status outputs of the wheel PWM driver.
interface wheel_pwm_driver_if #(
  parameter int CHANNELS = 2,
  parameter int SPEED_W  = 6
);
  logic                        enable_in;
  logic                        stop_in;
  logic [CHANNELS*SPEED_W-1:0] speed_in;
  logic [CHANNELS-1:0]         pwm_out;
  logic                        frame_start_out;
  logic [CHANNELS*SPEED_W-1:0] applied_out;
  modport master (output enable_in, stop_in, speed_in, input pwm_out, frame_start_out, applied_out);
  modport slave  (input enable_in, stop_in, speed_in, output pwm_out, frame_start_out, applied_out);
endinterface

// File: rtl/wheel_pwm_channel.sv
// wheel_pwm_channel: one servo output; applied speed updates only at frame boundaries.
module wheel_pwm_channel
  import wheel_pkg::*;
#(
  parameter int SPEED_W    = SPEED_W_DEF,
  parameter int CW         = 8,
  parameter int PULSE_MIN  = 10,
  parameter int PULSE_STEP = 2,
  parameter int SLEW_STEP  = 4,
  parameter bit INVERT     = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_wrap,
  input  logic               i_enable,
  input  logic               i_stop,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [CW-1:0]      i_cnt_nxt,
  output logic               o_pwm,
  output logic [SPEED_W-1:0] o_applied
);
  logic [SPEED_W-1:0] r_applied, w_target, w_applied_nxt;
  logic [CW-1:0]      w_width;
  logic               r_en, r_pwm, w_en_nxt;
  always_comb begin
    w_target      = INVERT ? SPEED_W'(mirror_speed(int'(i_speed), SPEED_W)) : i_speed;
    w_en_nxt      = i_wrap ? i_enable : r_en;
    w_applied_nxt = !i_wrap ? r_applied :
                    (!i_enable || i_stop) ? SPEED_W'(mid_of(SPEED_W)) :
                    SPEED_W'(slew_toward(int'(r_applied), int'(w_target), SLEW_STEP));
    w_width       = CW'(PULSE_MIN + int'(w_applied_nxt) * PULSE_STEP);
  end
  // Pulse decoded from next-state so the output flop never glitches.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_applied <= SPEED_W'(mid_of(SPEED_W));
      r_en      <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      r_applied <= w_applied_nxt;
      r_en      <= w_en_nxt;
      r_pwm     <= w_en_nxt && (i_cnt_nxt < w_width);
    end
  assign o_pwm     = r_pwm;
  assign o_applied = r_applied;
endmodule

// File: rtl/wheel_pwm_driver.sv
// wheel_pwm_driver: N-channel servo PWM with mirror, slew limit, e-stop and enable.
module wheel_pwm_driver
  import wheel_pkg::*;
#(
  parameter int                  CHANNELS    = 2,
  parameter int                  SPEED_W     = SPEED_W_DEF,
  parameter int                  PERIOD      = 2_000_000,
  parameter int                  PULSE_MIN   = 100_000,
  parameter int                  PULSE_STEP  = 1563,
  parameter int                  SLEW_STEP   = 4,
  parameter logic [CHANNELS-1:0] INVERT_MASK = 2'b10
) (
  input logic                  clk_in,
  input logic                  rst_in,
  wheel_pwm_driver_if.slave    bus
);
  localparam int CW = $clog2(PERIOD);
  if (PULSE_MIN + (2**SPEED_W - 1) * PULSE_STEP >= PERIOD) begin : g_bad_timing
    $error("wheel_pwm_driver: widest pulse does not fit in PERIOD");
  end
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic                        r_frame_start, w_wrap;
  logic [CHANNELS-1:0]         w_pwm;
  logic [CHANNELS*SPEED_W-1:0] w_applied;
  assign w_wrap    = r_cnt == CW'(PERIOD - 1);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_frame_start <= w_cnt_nxt == '0;
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    wheel_pwm_channel #(
      .SPEED_W(SPEED_W), .CW(CW), .PULSE_MIN(PULSE_MIN), .PULSE_STEP(PULSE_STEP),
      .SLEW_STEP(SLEW_STEP), .INVERT(INVERT_MASK[c])
    ) u_ch (
      .clk_in(clk_in), .rst_in(rst_in), .i_wrap(w_wrap),
      .i_enable(bus.enable_in), .i_stop(bus.stop_in),
      .i_speed(bus.speed_in[c*SPEED_W +: SPEED_W]), .i_cnt_nxt(w_cnt_nxt),
      .o_pwm(w_pwm[c]), .o_applied(w_applied[c*SPEED_W +: SPEED_W])
    );
  end
  assign bus.pwm_out         = w_pwm;
  assign bus.applied_out     = w_applied;
  assign bus.frame_start_out = r_frame_start;
endmodule
